// File: rtl/run_ctrl.sv
// Run sequencer for the single-cycle core: holds the core in reset, enables it,
// watches for the terminal PC or a watchdog expiry, and reports a level done.
module run_ctrl #(
  parameter int D       = 12,
  parameter int CW      = 16,
  parameter int DONE_PC = 256,
  parameter int MAX_CYC = 16'hFFFF,
  parameter int RST_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [D-1:0]  prog_ctr,
  output logic          core_rst,
  output logic          core_en,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycles
);

  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYC - 1);
  localparam logic [D-1:0]  DONE_PC_V = D'(DONE_PC);
  localparam logic [CW-1:0] WD_LAST   = CW'(MAX_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  logic [RW-1:0] rst_cnt;

  // NOTE: all state and outputs update with non-blocking assignments in one
  // clocked block, so every output is a flop and reads of 'cycles' below see
  // the pre-increment value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      core_rst <= 1'b1;
      core_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      cycles   <= '0;
      rst_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            state   <= S_CLEAR;
            busy    <= 1'b1;
            cycles  <= '0;
            timeout <= 1'b0;
            rst_cnt <= RST_LOAD;
          end
        end

        S_CLEAR: begin
          if (!req) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (rst_cnt == '0) begin
            state    <= S_RUN;
            core_rst <= 1'b0;
            core_en  <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end

        S_RUN: begin
          // The exit cycle is itself a RUN cycle, so count before deciding.
          if (cycles != '1) cycles <= cycles + 1'b1;
          if (!req) begin
            state    <= S_IDLE;
            core_rst <= 1'b1;
            core_en  <= 1'b0;
            busy     <= 1'b0;
          end else if (prog_ctr == DONE_PC_V) begin
            state   <= S_DRAIN;
            core_en <= 1'b0;
            timeout <= 1'b0;
          end else if (cycles == WD_LAST) begin
            state   <= S_DRAIN;
            core_en <= 1'b0;
            timeout <= 1'b1;
          end
        end

        S_DRAIN: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        S_DONE: begin
          if (!req) begin
            state    <= S_IDLE;
            done     <= 1'b0;
            core_rst <= 1'b1;
          end
        end

        default: begin
          state    <= S_IDLE;
          core_rst <= 1'b1;
          core_en  <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: normal run, watchdog, tie, abort, re-request
// gating and asynchronous reset, with hand-computed expectations.
module tb_run_ctrl;

  localparam int D       = 12;
  localparam int CW      = 16;
  localparam int DONE_PC = 256;
  localparam int MAX_CYC = 20;
  localparam int RST_CYC = 2;

  logic          clk;
  logic          reset;
  logic          req;
  logic [D-1:0]  prog_ctr;
  logic          core_rst;
  logic          core_en;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycles;

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;

  run_ctrl #(
    .D(D), .CW(CW), .DONE_PC(DONE_PC), .MAX_CYC(MAX_CYC), .RST_CYC(RST_CYC)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .prog_ctr(prog_ctr),
    .core_rst(core_rst), .core_en(core_en), .busy(busy), .done(done),
    .timeout(timeout), .cycles(cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later; also track output invariants.
  task automatic step();
    @(posedge clk);
    #1;
    if (core_en && core_rst) viol++;
    if (done && busy) viol++;
  endtask

  // Drive a run already requested; PC hits DONE_PC on RUN cycle pc_hit
  // (0 = never) and req drops during RUN cycle abort_at (0 = never).
  task automatic run_until(input int pc_hit, input int abort_at,
                           output int clear_cnt, output int en_cnt, output int lat);
    int since_en;
    bit ended;
    clear_cnt = 0;
    en_cnt    = 0;
    lat       = 0;
    since_en  = 0;
    ended     = 1'b0;
    for (int i = 0; i < 100 && !ended; i++) begin
      step();
      if (core_en) begin
        en_cnt++;
        since_en = 0;
        prog_ctr = (en_cnt == pc_hit) ? D'(DONE_PC) : D'(en_cnt * 3);
        if (en_cnt == abort_at) req = 1'b0;
      end else begin
        since_en++;
        if (core_rst && busy) clear_cnt++;
      end
      if (done || !busy) begin
        ended = 1'b1;
        lat   = since_en;
      end
    end
    if (!ended) check("run_bound", 32'(0), 32'(1));
    prog_ctr = '0;
  endtask

  int  c_cnt, e_cnt, lat;
  bit  stayed;

  initial begin
    reset    = 1'b0;
    req      = 1'b0;
    prog_ctr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_core_rst", 32'(core_rst), 32'(1));
    check("rst_core_en",  32'(core_en),  32'(0));
    check("rst_busy",     32'(busy),     32'(0));
    check("rst_done",     32'(done),     32'(0));
    check("rst_cycles",   32'(cycles),   32'(0));
    reset = 1'b1;
    step();
    check("idle_core_rst", 32'(core_rst), 32'(1));

    // Normal run: match on RUN cycle 10.
    req = 1'b1;
    run_until(10, 0, c_cnt, e_cnt, lat);
    check("norm_clear_cyc", 32'(c_cnt),   32'(2));
    check("norm_en_cyc",    32'(e_cnt),   32'(10));
    check("norm_done",      32'(done),    32'(1));
    check("norm_latency",   32'(lat),     32'(2));
    check("norm_timeout",   32'(timeout), 32'(0));
    check("norm_cycles",    32'(cycles),  32'(10));
    req = 1'b0;
    step();
    check("norm_done_clr",  32'(done),     32'(0));
    check("norm_idle_rst",  32'(core_rst), 32'(1));
    check("norm_cyc_held",  32'(cycles),   32'(10));

    // Watchdog: PC never matches.
    req = 1'b1;
    run_until(0, 0, c_cnt, e_cnt, lat);
    check("wd_en_cyc",  32'(e_cnt),   32'(20));
    check("wd_done",    32'(done),    32'(1));
    check("wd_timeout", 32'(timeout), 32'(1));
    check("wd_cycles",  32'(cycles),  32'(20));

    // req held high through DONE must not start a new run.
    stayed = 1'b1;
    repeat (10) begin
      step();
      if (!done || busy || core_en || cycles != 20) stayed = 1'b0;
    end
    check("hold_in_done", 32'(stayed), 32'(1));
    req = 1'b0;
    step();
    req = 1'b1;
    step();
    check("rereq_busy",    32'(busy),     32'(1));
    check("rereq_rst",     32'(core_rst), 32'(1));
    check("rereq_cycles",  32'(cycles),   32'(0));
    check("rereq_timeout", 32'(timeout), 32'(0));

    // Tie on RUN cycle 20: PC match wins.
    run_until(20, 0, c_cnt, e_cnt, lat);
    check("tie_en_cyc",  32'(e_cnt),   32'(20));
    check("tie_done",    32'(done),    32'(1));
    check("tie_timeout", 32'(timeout), 32'(0));
    check("tie_cycles",  32'(cycles),  32'(20));
    req = 1'b0;
    step();

    // Abort on RUN cycle 5.
    req = 1'b1;
    run_until(0, 5, c_cnt, e_cnt, lat);
    check("abort_en_cyc",  32'(e_cnt),    32'(5));
    check("abort_done",    32'(done),     32'(0));
    check("abort_busy",    32'(busy),     32'(0));
    check("abort_core_en", 32'(core_en),  32'(0));
    check("abort_rst",     32'(core_rst), 32'(1));
    check("abort_cycles",  32'(cycles),   32'(5));
    step();
    check("abort_no_done", 32'(done),     32'(0));

    // Abort during CLEAR.
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    check("clr_abort_busy",   32'(busy),   32'(0));
    check("clr_abort_cycles", 32'(cycles), 32'(0));

    // Asynchronous reset mid-RUN, no clock edge needed.
    req = 1'b1;
    repeat (5) step();
    check("mid_run_en", 32'(core_en), 32'(1));
    #2;
    reset = 1'b0;
    #1;
    check("async_core_rst", 32'(core_rst), 32'(1));
    check("async_core_en",  32'(core_en),  32'(0));
    check("async_busy",     32'(busy),     32'(0));
    check("async_cycles",   32'(cycles),   32'(0));
    req   = 1'b0;
    reset = 1'b1;
    step();
    check("post_rst_core_rst", 32'(core_rst), 32'(1));
    check("post_rst_busy",     32'(busy),     32'(0));

    check("invariants", 32'(viol), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
